i2c_master_burst: RTL and testbench
===================================

Name: i2c_master_burst

Overview:
- Parametrised successor to the team's single-byte I2C master.
- Runs a complete I2C transaction of 0..2^LEN_W-1 data bytes, read or write, with 7-bit addressing, ACK/NACK detection, slave clock stretching and a programmable SCL rate.
- Sits between a host controller (start/busy/done and byte-stream handshakes) and open-drain SDA/SCL pads; the pads are instantiated outside this block.

Parameters:
- CLK_DIV, 250, clk cycles per SCL quarter-period (min 2); SCL period = 4*CLK_DIV.
- LEN_W, 4, width of the byte-count field.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-low reset
- start  input  1  1-cycle request; accepted only while busy=0
- rw  input  1  0=write, 1=read; latched on accept
- addr  input  7  slave address; latched on accept
- nbytes  input  LEN_W  data byte count; 0 = address-only probe; latched on accept
- tx_data  input  8  write byte; sampled in the cycle tx_req=1
- tx_req  output  1  1-cycle pulse requesting the next write byte
- rx_data  output  8  last received byte; held until the next rx_valid
- rx_valid  output  1  1-cycle pulse, rx_data valid
- busy  output  1  high from accept until the bus-free time completes
- done  output  1  1-cycle pulse at transaction end
- nack  output  1  set when the slave NACKs; cleared on next accept
- sda_i  input  1  SDA pad level
- sda_oe  output  1  1 = drive SDA low, 0 = release
- scl_i  input  1  SCL pad level, used for stretching
- scl_oe  output  1  1 = drive SCL low, 0 = release

Behaviour:
- Reset (async, active-low): sda_oe=0, scl_oe=0, busy=0, done=0, tx_req=0, rx_valid=0, nack=0, rx_data=0, state IDLE.
  - Reset mid-transaction releases both lines immediately. No STOP is generated.
- sda_i and scl_i are synchronised through 2 flops before any use.
- Bit timing: each bit spans 4 quarters Q0..Q3 of CLK_DIV clocks.
  - SCL is held low in Q0–Q1; SDA changes at the Q0/Q1 boundary.
  - SCL is released in Q2. The Q2 counter does not run until synced scl_i=1 (stretching, unbounded wait).
  - SDA is sampled at the Q2/Q3 boundary.
- States: IDLE, START, ADDR, ADDR_ACK, WRITE, WACK, READ, MACK, STOP.
- IDLE:
  - start=1 latches rw/addr/nbytes, clears nack, sets busy, goes to START.
  - start while busy=1 is ignored.
- START: SDA released and SCL released for 2 quarters, then sda_oe=1 for 2 quarters with SCL high, then SCL low.
- ADDR: shifts {addr,rw} MSB first, 8 bits.
- ADDR_ACK: SDA released for the 9th bit.
  - sda_i=1 sets nack and goes to STOP.
  - nbytes=0 goes to STOP.
  - Otherwise rw=0 goes to WRITE with a tx_req pulse at the ACK sample cycle; rw=1 goes to READ.
- WRITE: shifts the byte captured at tx_req, MSB first, then WACK.
- WACK:
  - NACK sets nack and goes to STOP.
  - Remaining count 0 goes to STOP.
  - Otherwise tx_req pulses and the next byte is sent.
- READ: 8 bits sampled MSB first. rx_valid pulses one cycle after the 8th sample with rx_data updated; then MACK.
- MACK: sda_oe=1 (ACK) if more bytes remain; SDA released (NACK) on the last byte.
- STOP: sda_oe=1 with SCL low for 2 quarters, SCL released (stretch honoured) for 2 quarters, then sda_oe=0.
  - Then 4 quarters bus-free; done pulses and busy drops in the same cycle; return to IDLE.
- The byte counter decrements per completed data byte and never wraps.
- nack remains valid until the next accept.

Test Plan:
- CLK_DIV=4, write, addr=0x66, nbytes=1, tx_data=0xF0, slave ACKs:
  - SDA bytes 0xCC then 0xF0; 18 SCL rising edges; tx_req×1; done×1; nack=0.
- Write, addr=0x66, nbytes=2, slave NACKs the address:
  - nack=1; STOP after the 9th SCL edge; no tx_req; done pulses.
- Read, addr=0x50, nbytes=3, slave returns 0xA5, 0x5A, 0xFF:
  - 3 rx_valid pulses carrying those values.
  - Master drives ACK (sda_oe=1) on bytes 1–2 and releases SDA on byte 3.
  - 36 SCL rising edges.
- Slave holds scl_i low for 50 clocks in the 3rd address bit:
  - That SCL high phase starts ≥50 clocks late; shifted data is unchanged; transaction completes normally.
- reset=0 during a WRITE byte:
  - sda_oe=0, scl_oe=0, busy=0 in the same cycle.
  - After release, a new 1-byte write completes correctly.
- nbytes=0 probe to 0x3C with ACK, plus a start pulse while busy:
  - STOP follows the ACK; no tx_req or rx_valid; the second start is ignored; exactly one done.

Source files
------------

// File: rtl/i2c_master_burst.sv
// Purpose: I2C master running one START/address/N-byte/STOP burst, read or write.
// Latency: 4*CLK_DIV clocks per SCL bit, plus slave stretch time; done follows 4 bus-free quarters.
// Backpressure: start is ignored while busy; write bytes are pulled one tx_req at a time; slave holds SCL low to stall.
module i2c_master_burst #(
  parameter int CLK_DIV = 250,
  parameter int LEN_W   = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             rw,
  input  logic [6:0]       addr,
  input  logic [LEN_W-1:0] nbytes,
  input  logic [7:0]       tx_data,
  output logic             tx_req,
  output logic [7:0]       rx_data,
  output logic             rx_valid,
  output logic             busy,
  output logic             done,
  output logic             nack,
  input  logic             sda_i,
  output logic             sda_oe,
  input  logic             scl_i,
  output logic             scl_oe
);

  localparam int DIV_W = $clog2(CLK_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  typedef enum logic [3:0] {
    IDLE, START, ADDR, ADDR_ACK, WRITE, WACK, READ, MACK, STOP
  } state_t;

  state_t           state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [1:0]       qtr_q, qtr_d;
  logic [2:0]       bit_q, bit_d;      // bit index in a byte; in STOP bit 0 marks the bus-free phase
  logic [7:0]       shift_q, shift_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic             rw_q, rw_d;
  logic             sda_oe_q, sda_oe_d;
  logic             nack_q, nack_d;
  logic             done_q, done_d;
  logic             rx_valid_q, rx_valid_d;
  logic [7:0]       rx_data_q, rx_data_d;
  logic             sda_meta_q, sda_meta_d, sda_sync_q, sda_sync_d;
  logic             scl_meta_q, scl_meta_d, scl_sync_q, scl_sync_d;

  logic bit_phase, stop_clk, stretch_wait, tick;
  logic q0_end, q1_end, q2_end, q3_end, last_bit, more;

  // State register, quarter timer and datapath flops
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      div_q      <= '0;
      qtr_q      <= '0;
      bit_q      <= '0;
      shift_q    <= '0;
      cnt_q      <= '0;
      rw_q       <= 1'b0;
      sda_oe_q   <= 1'b0;
      nack_q     <= 1'b0;
      done_q     <= 1'b0;
      rx_valid_q <= 1'b0;
      rx_data_q  <= '0;
      sda_meta_q <= 1'b1;
      sda_sync_q <= 1'b1;
      scl_meta_q <= 1'b1;
      scl_sync_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      div_q      <= div_d;
      qtr_q      <= qtr_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      cnt_q      <= cnt_d;
      rw_q       <= rw_d;
      sda_oe_q   <= sda_oe_d;
      nack_q     <= nack_d;
      done_q     <= done_d;
      rx_valid_q <= rx_valid_d;
      rx_data_q  <= rx_data_d;
      sda_meta_q <= sda_meta_d;
      sda_sync_q <= sda_sync_d;
      scl_meta_q <= scl_meta_d;
      scl_sync_q <= scl_sync_d;
    end
  end

  // Next-state, bit sequencing and pad control
  always_comb begin
    sda_meta_d = sda_i;
    sda_sync_d = sda_meta_q;
    scl_meta_d = scl_i;
    scl_sync_d = scl_meta_q;

    bit_phase = (state_q == ADDR) || (state_q == ADDR_ACK) || (state_q == WRITE) ||
                (state_q == WACK) || (state_q == READ) || (state_q == MACK);
    stop_clk  = (state_q == STOP) && !bit_q[0];
    // Q2 only counts once the released SCL is seen high: this is the stretch wait
    stretch_wait = (qtr_q == 2'd2) && !scl_sync_q && (bit_phase || stop_clk);
    tick     = (state_q != IDLE) && !stretch_wait && (div_q == DIV_LAST);
    q0_end   = tick && (qtr_q == 2'd0);
    q1_end   = tick && (qtr_q == 2'd1);
    q2_end   = tick && (qtr_q == 2'd2);
    q3_end   = tick && (qtr_q == 2'd3);
    last_bit = (bit_q == 3'd7);
    more     = (cnt_q != '0);

    state_d    = state_q;
    div_d      = (state_q == IDLE || tick) ? '0 : (stretch_wait ? div_q : div_q + 1'b1);
    qtr_d      = tick ? qtr_q + 2'd1 : qtr_q;
    bit_d      = bit_q;
    shift_d    = shift_q;
    cnt_d      = cnt_q;
    rw_d       = rw_q;
    sda_oe_d   = sda_oe_q;
    nack_d     = nack_q;
    done_d     = 1'b0;
    rx_valid_d = 1'b0;
    rx_data_d  = rx_data_q;
    tx_req     = 1'b0;

    case (state_q)
      IDLE: begin
        sda_oe_d = 1'b0;
        if (start) begin
          rw_d    = rw;
          shift_d = {addr, rw};
          cnt_d   = nbytes;
          nack_d  = 1'b0;
          bit_d   = '0;
          qtr_d   = '0;
          state_d = START;
        end
      end
      START: begin
        if (q1_end) sda_oe_d = 1'b1;   // SDA falls while SCL is high
        if (q3_end) state_d = ADDR;
      end
      ADDR, WRITE: begin
        if (q0_end) sda_oe_d = ~shift_q[7];
        if (q3_end) begin
          shift_d = {shift_q[6:0], 1'b0};
          bit_d   = bit_q + 1'b1;
          if (last_bit) begin
            state_d = (state_q == ADDR) ? ADDR_ACK : WACK;
            if (state_q == WRITE && more) cnt_d = cnt_q - 1'b1;
          end
        end
      end
      ADDR_ACK, WACK: begin
        if (q0_end) sda_oe_d = 1'b0;
        if (q2_end) begin
          if (sda_sync_q) begin
            nack_d = 1'b1;
          end else if (more && !rw_q) begin
            tx_req  = 1'b1;
            shift_d = tx_data;
          end
        end
        if (q3_end) begin
          bit_d = '0;
          if (nack_q || !more) state_d = STOP;
          else                 state_d = rw_q ? READ : WRITE;
        end
      end
      READ: begin
        if (q0_end) sda_oe_d = 1'b0;
        if (q2_end) begin
          shift_d = {shift_q[6:0], sda_sync_q};
          if (last_bit) begin
            rx_valid_d = 1'b1;
            rx_data_d  = {shift_q[6:0], sda_sync_q};
          end
        end
        if (q3_end) begin
          bit_d = bit_q + 1'b1;
          if (last_bit) begin
            state_d = MACK;
            if (more) cnt_d = cnt_q - 1'b1;
          end
        end
      end
      MACK: begin
        if (q0_end) sda_oe_d = more;   // ACK while bytes remain, NACK on the last
        if (q3_end) begin
          bit_d   = '0;
          state_d = more ? READ : STOP;
        end
      end
      STOP: begin
        if (!bit_q[0]) begin
          if (q0_end) sda_oe_d = 1'b1; // pull SDA low only after SCL is already low
          if (q3_end) begin
            sda_oe_d = 1'b0;           // SDA rises with SCL high: STOP
            bit_d    = 3'd1;
          end
        end else if (q3_end) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // SCL is low in Q0-Q1 of every bit and of the STOP clock, released otherwise
  assign scl_oe   = (bit_phase || stop_clk) && (qtr_q < 2'd2);
  assign sda_oe   = sda_oe_q;
  assign busy     = (state_q != IDLE);
  assign done     = done_q;
  assign nack     = nack_q;
  assign rx_valid = rx_valid_q;
  assign rx_data  = rx_data_q;

endmodule

// File: tb/tb_i2c_master_burst.sv
// Bench for i2c_master_burst: behavioural open-drain slave plus scoreboards.
// Bytes seen on SDA, read data and master ACK bits are checked against queues filled at stimulus time.
module tb_i2c_master_burst;
  localparam int CLK_DIV = 4;
  localparam int LEN_W   = 4;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             start = 1'b0;
  logic             rw = 1'b0;
  logic [6:0]       addr = '0;
  logic [LEN_W-1:0] nbytes = '0;
  logic [7:0]       tx_data = '0;
  logic             tx_req, rx_valid, busy, done, nack, sda_oe, scl_oe;
  logic [7:0]       rx_data;
  logic             sl_sda_low = 1'b0;
  logic             sl_stretch = 1'b0;
  logic             sda_bus, scl_bus;

  assign sda_bus = ~(sda_oe | sl_sda_low);
  assign scl_bus = ~(scl_oe | sl_stretch);

  always #5 clk = ~clk;

  i2c_master_burst #(.CLK_DIV(CLK_DIV), .LEN_W(LEN_W)) dut (
    .clk(clk), .reset(reset), .start(start), .rw(rw), .addr(addr), .nbytes(nbytes),
    .tx_data(tx_data), .tx_req(tx_req), .rx_data(rx_data), .rx_valid(rx_valid),
    .busy(busy), .done(done), .nack(nack), .sda_i(sda_bus), .sda_oe(sda_oe),
    .scl_i(scl_bus), .scl_oe(scl_oe)
  );

  int total = 0;
  int bad = 0;
  int n_done, n_txreq, n_rxv, n_rise, n_stop, n_sbytes;
  logic [7:0] exp_byte[$];   // bytes the slave must see on SDA (address, write data)
  logic [7:0] exp_rx[$];     // bytes the host must see on rx_data
  logic       exp_mack[$];   // 1 = master must ACK this read byte
  logic [7:0] rd_q[$];       // bytes the slave returns
  logic [7:0] tx_q[$];       // bytes the host supplies on tx_req
  logic cfg_addr_ack = 1'b1;
  logic cfg_data_ack = 1'b1;
  logic stretch_arm = 1'b0;
  int   st_cnt = 0;
  int   st_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Host side: count pulses, score read data, refill tx_data after each request
  always @(negedge clk) if (done) begin
    n_done++;
    chk("busy_with_done", busy, 1'b0);
  end

  always @(negedge clk) if (rx_valid) begin
    n_rxv++;
    if (exp_rx.size() > 0) chk("rx_data", rx_data, exp_rx.pop_front());
  end

  always @(negedge clk) if (tx_req) begin
    n_txreq++;
    @(posedge clk);
    #1;
    if (tx_q.size() > 0) void'(tx_q.pop_front());
    tx_data = (tx_q.size() > 0) ? tx_q[0] : 8'h00;
  end

  // Behavioural slave working on the wired-AND bus levels
  logic sda_now, scl_now, sda_prev = 1'b1, scl_prev = 1'b1;
  logic sl_active = 1'b0, is_addr = 1'b0, sl_rw = 1'b0, addr_ok = 1'b0, last_mack = 1'b0;
  logic [7:0] sh = '0, rdb = '0;
  int bitn = 0;

  always @(negedge clk) begin
    sda_now = ~(sda_oe | sl_sda_low);
    scl_now = ~(scl_oe | sl_stretch);
    if (!reset) begin
      sl_active = 1'b0; sl_sda_low = 1'b0; sl_stretch = 1'b0; bitn = 0;
      sda_prev = 1'b1; scl_prev = 1'b1;
    end else begin
      if (sl_stretch) begin
        if (!scl_oe) st_cnt++;
        else if (st_cnt > 0) st_bad++;
        if (st_cnt >= 50) sl_stretch = 1'b0;
      end
      if (scl_prev && scl_now && sda_prev && !sda_now) begin
        sl_active = 1'b1; bitn = 0; is_addr = 1'b1; addr_ok = 1'b0;
      end else if (scl_prev && scl_now && !sda_prev && sda_now) begin
        if (sl_active) n_stop++;
        sl_active = 1'b0; sl_sda_low = 1'b0;
      end else if (sl_active && !scl_prev && scl_now) begin
        n_rise++;
        if (bitn < 8) sh = {sh[6:0], sda_now};
        else if (sl_rw && !is_addr && exp_mack.size() > 0) begin
          last_mack = !sda_now;
          chk("master_ack", last_mack, exp_mack.pop_front());
        end
        bitn++;
      end else if (sl_active && scl_prev && !scl_now) begin
        if (bitn == 8) begin
          if (is_addr || !sl_rw) begin
            n_sbytes++;
            if (exp_byte.size() > 0) chk("sda_byte", sh, exp_byte.pop_front());
            if (is_addr) begin
              sl_rw = sh[0]; addr_ok = cfg_addr_ack; sl_sda_low = cfg_addr_ack;
            end else begin
              sl_sda_low = cfg_data_ack;
            end
          end else begin
            sl_sda_low = 1'b0;
          end
        end else if (bitn == 9) begin
          bitn = 0;
          if (sl_rw && addr_ok && (is_addr || last_mack) && rd_q.size() > 0) begin
            rdb = rd_q.pop_front();
            sl_sda_low = !rdb[7];
          end else begin
            sl_sda_low = 1'b0;
          end
          is_addr = 1'b0;
        end else if (sl_rw && !is_addr && bitn >= 1 && bitn <= 7) begin
          sl_sda_low = !rdb[7-bitn];
        end
        if (stretch_arm && is_addr && bitn == 2) begin
          sl_stretch = 1'b1; st_cnt = 0; stretch_arm = 1'b0;
        end
      end
      sda_prev = sda_now;
      scl_prev = scl_now;
    end
  end

  task automatic clear_counts();
    n_done = 0; n_txreq = 0; n_rxv = 0; n_rise = 0; n_stop = 0; n_sbytes = 0;
  endtask

  task automatic set_tx(input logic [7:0] b0, input logic [7:0] b1);
    tx_q.delete();
    tx_q.push_back(b0);
    tx_q.push_back(b1);
    tx_data = b0;
  endtask

  task automatic pulse_start(input logic r, input logic [6:0] a, input logic [LEN_W-1:0] n);
    @(negedge clk);
    rw = r; addr = a; nbytes = n; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done();
    int t = 0;
    while (n_done == 0 && t < 20000) begin
      @(negedge clk);
      t++;
    end
    chk("done_in_time", (t < 20000), 1'b1);
    repeat (2) @(negedge clk);
  endtask

  task automatic do_xfer(input logic r, input logic [6:0] a, input logic [LEN_W-1:0] n);
    clear_counts();
    exp_byte.push_front({a, r});
    pulse_start(r, a, n);
    wait_done();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int t;
    // reset state
    #1;
    chk("rst_sda_oe", sda_oe, 1'b0);
    chk("rst_scl_oe", scl_oe, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_tx_req", tx_req, 1'b0);
    chk("rst_rx_valid", rx_valid, 1'b0);
    chk("rst_nack", nack, 1'b0);
    chk("rst_rx_data", rx_data, 8'h00);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);

    // 1-byte write, slave ACKs: bus carries 0xCC then 0xF0
    set_tx(8'hF0, 8'h00);
    exp_byte.push_back(8'hF0);
    do_xfer(1'b0, 7'h66, 4'd1);
    chk("w1_txreq", n_txreq, 1);
    chk("w1_done", n_done, 1);
    chk("w1_nack", nack, 1'b0);
    chk("w1_bytes", n_sbytes, 2);
    chk("w1_data_clks", n_rise - 1, 18);   // last rise belongs to the STOP
    chk("w1_stop", n_stop, 1);
    chk("w1_busy", busy, 1'b0);

    // address NACK: STOP right after the 9th clock, no data requested
    cfg_addr_ack = 1'b0;
    set_tx(8'h11, 8'h22);
    do_xfer(1'b0, 7'h66, 4'd2);
    chk("an_nack", nack, 1'b1);
    chk("an_txreq", n_txreq, 0);
    chk("an_data_clks", n_rise - 1, 9);
    chk("an_done", n_done, 1);
    chk("an_stop", n_stop, 1);
    cfg_addr_ack = 1'b1;
    tx_q.delete();

    // 3-byte read: ACK, ACK, NACK
    rd_q.delete();
    rd_q.push_back(8'hA5); rd_q.push_back(8'h5A); rd_q.push_back(8'hFF);
    exp_rx.push_back(8'hA5); exp_rx.push_back(8'h5A); exp_rx.push_back(8'hFF);
    exp_mack.push_back(1'b1); exp_mack.push_back(1'b1); exp_mack.push_back(1'b0);
    do_xfer(1'b1, 7'h50, 4'd3);
    chk("rd_rxv", n_rxv, 3);
    chk("rd_data_clks", n_rise - 1, 36);
    chk("rd_nack", nack, 1'b0);
    chk("rd_mack_left", exp_mack.size(), 0);
    chk("rd_rx_hold", rx_data, 8'hFF);
    chk("rd_done", n_done, 1);

    // slave stretches the 3rd address bit by 50 clocks
    stretch_arm = 1'b1;
    st_bad = 0;
    set_tx(8'h81, 8'h00);
    exp_byte.push_back(8'h81);
    do_xfer(1'b0, 7'h66, 4'd1);
    chk("st_len", st_cnt, 50);
    chk("st_scl_held", st_bad, 0);
    chk("st_bytes", n_sbytes, 2);
    chk("st_data_clks", n_rise - 1, 18);
    chk("st_done", n_done, 1);
    chk("st_nack", nack, 1'b0);

    // reset in the middle of a write byte
    clear_counts();
    set_tx(8'hAA, 8'h55);
    exp_byte.push_front({7'h66, 1'b0});
    exp_byte.push_back(8'hAA);
    pulse_start(1'b0, 7'h66, 4'd2);
    t = 0;
    while (n_txreq == 0 && t < 2000) begin
      @(negedge clk);
      t++;
    end
    chk("rs_txreq_seen", (t < 2000), 1'b1);
    repeat (30) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rs_sda_oe", sda_oe, 1'b0);
    chk("rs_scl_oe", scl_oe, 1'b0);
    chk("rs_busy", busy, 1'b0);
    chk("rs_done", n_done, 0);
    exp_byte.delete();
    tx_q.delete();
    repeat (4) @(negedge clk);
    reset = 1'b1;
    repeat (4) @(negedge clk);
    set_tx(8'h5A, 8'h00);
    exp_byte.push_back(8'h5A);
    do_xfer(1'b0, 7'h66, 4'd1);
    chk("rs2_bytes", n_sbytes, 2);
    chk("rs2_txreq", n_txreq, 1);
    chk("rs2_done", n_done, 1);
    chk("rs2_nack", nack, 1'b0);

    // address-only probe, with a second start while busy
    clear_counts();
    tx_q.delete();
    exp_byte.push_back({7'h3C, 1'b0});
    pulse_start(1'b0, 7'h3C, 4'd0);
    repeat (20) @(negedge clk);
    pulse_start(1'b1, 7'h11, 4'd5);
    wait_done();
    repeat (200) @(negedge clk);
    chk("pr_done", n_done, 1);
    chk("pr_txreq", n_txreq, 0);
    chk("pr_rxv", n_rxv, 0);
    chk("pr_data_clks", n_rise - 1, 9);
    chk("pr_bytes", n_sbytes, 1);
    chk("pr_nack", nack, 1'b0);
    chk("pr_idle", busy, 1'b0);
    chk("sb_bytes_left", exp_byte.size(), 0);
    chk("sb_rx_left", exp_rx.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
